// File: rtl/hamming74_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module   : hamming74_encoder_tx
// Brief    : Hamming(7,4) encoder with optional single-bit error injection,
//            feeding a small valid/ready FIFO towards the corrector.
// Revision : 1.0 - initial release
// ============================================================================
module hamming74_encoder_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic [2:0]       INJ_POS,
    output logic [1:7]       CW,
    output logic             CW_VALID,
    input  logic             CW_READY,
    output logic [CNT_W-1:0] TX_COUNT,
    output logic [CNT_W-1:0] INJ_COUNT
);

    localparam int              PTR_W        = $clog2(DEPTH);
    localparam logic [PTR_W:0]  c_FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  c_CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_STAT_ONE  = CNT_W'(1);

    logic [1:7]       w_code;
    logic [1:7]       w_inj_mask;
    logic [1:7]       w_stored;
    logic             w_push;
    logic             w_pop;

    logic [1:7]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_tx_count;
    logic [CNT_W-1:0] r_inj_count;

    // Data at positions 3,5,6,7; parity at 1,2,4 matching the corrector's syndrome.
    assign w_code[3] = DIN[0];
    assign w_code[5] = DIN[1];
    assign w_code[6] = DIN[2];
    assign w_code[7] = DIN[3];
    assign w_code[1] = DIN[0] ^ DIN[1] ^ DIN[3];
    assign w_code[2] = DIN[0] ^ DIN[2] ^ DIN[3];
    assign w_code[4] = DIN[1] ^ DIN[2] ^ DIN[3];

    for (genvar i = 1; i <= 7; i++) begin : g_inj_mask
        assign w_inj_mask[i] = (INJ_POS == 3'(i));
    end

    assign w_stored  = w_code ^ w_inj_mask;

    assign DIN_READY = (r_count != c_FULL_COUNT);
    assign CW_VALID  = (r_count != '0);
    assign CW        = CW_VALID ? r_mem[r_rd_ptr] : '0;
    assign TX_COUNT  = r_tx_count;
    assign INJ_COUNT = r_inj_count;

    assign w_push = DIN_VALID && DIN_READY;
    assign w_pop  = CW_VALID && CW_READY;

    // Storage needs no reset: the occupancy counter alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_stored;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tx_count  <= '0;
            r_inj_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (INJ_POS != 3'd0) begin
                    r_inj_count <= r_inj_count + c_STAT_ONE;
                end
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_tx_count <= r_tx_count + c_STAT_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming74_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming74_encoder_tx
// Brief    : Randomised and directed bench against a queue-based model of the
//            encoder FIFO and a syndrome-based corrector model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming74_encoder_tx;

    localparam int c_DEPTH = 4;

    logic        CLK;
    logic        RESET;
    logic [3:0]  DIN;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [2:0]  INJ_POS;
    logic [1:7]  CW;
    logic        CW_VALID;
    logic        CW_READY;
    logic [15:0] TX_COUNT;
    logic [15:0] INJ_COUNT;

    hamming74_encoder_tx #(.DEPTH(c_DEPTH), .CNT_W(16)) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .INJ_POS   (INJ_POS),
        .CW        (CW),
        .CW_VALID  (CW_VALID),
        .CW_READY  (CW_READY),
        .TX_COUNT  (TX_COUNT),
        .INJ_COUNT (INJ_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [13:0] q[$];          // {inj[2:0], nibble[3:0], codeword[6:0]}
    logic [15:0] m_tx;
    logic [15:0] m_inj;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Codeword packed with position 1 in bit 6. Parity at power-of-two positions
    // covers every position whose index has that bit set.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [7:1] c;
        logic [6:0] r;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p <= 7; p++) begin
            if (p != 1 && p != 2 && p != 4) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            for (int j = 1; j <= 7; j++) begin
                if ((j & p) != 0 && j != p) c[p] = c[p] ^ c[j];
            end
        end
        for (int p = 1; p <= 7; p++) r[7-p] = c[p];
        return r;
    endfunction

    function automatic logic [6:0] inject(input logic [6:0] w, input logic [2:0] pos);
        logic [6:0] r;
        r = w;
        if (pos != 3'd0) r[7-pos] = ~r[7-pos];
        return r;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] w);
        logic [2:0] s;
        s = 3'd0;
        for (int j = 1; j <= 7; j++) begin
            if (w[7-j]) s = s ^ 3'(j);
        end
        return s;
    endfunction

    task automatic do_reset(input int n);
        RESET     = 1'b1;
        DIN_VALID = 1'b0;
        CW_READY  = 1'b0;
        DIN       = 4'd0;
        INJ_POS   = 3'd0;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        q.delete();
        m_tx  = '0;
        m_inj = '0;
        check_eq("rst_cw_valid",  32'(CW_VALID),  32'd0);
        check_eq("rst_din_ready", 32'(DIN_READY), 32'd1);
        check_eq("rst_cw",        32'(CW),        32'd0);
        check_eq("rst_tx_count",  32'(TX_COUNT),  32'd0);
        check_eq("rst_inj_count", 32'(INJ_COUNT), 32'd0);
    endtask

    // One clock: check outputs against the model, apply inputs, advance the model.
    task automatic cycle(input logic v, input logic [3:0] d, input logic [2:0] inj, input logic rdy);
        logic        do_push;
        logic        do_pop;
        logic [13:0] head;
        logic [6:0]  fixed;
        logic [2:0]  s;
        DIN_VALID = v;
        DIN       = d;
        INJ_POS   = inj;
        CW_READY  = rdy;
        check_eq("din_ready", 32'(DIN_READY), 32'(q.size() < c_DEPTH));
        check_eq("cw_valid",  32'(CW_VALID),  32'(q.size() != 0));
        if (q.size() != 0) check_eq("cw", 32'(CW), 32'(q[0][6:0]));
        else               check_eq("cw_idle", 32'(CW), 32'd0);
        check_eq("tx_count",  32'(TX_COUNT),  32'(m_tx));
        check_eq("inj_count", 32'(INJ_COUNT), 32'(m_inj));
        do_push = v && (q.size() < c_DEPTH);
        do_pop  = (q.size() != 0) && rdy;
        @(posedge CLK);
        if (do_pop) begin
            head  = q.pop_front();
            m_tx  = m_tx + 16'd1;
            s     = syndrome(head[6:0]);
            fixed = inject(head[6:0], s);
            check_eq("corrected", 32'(fixed), 32'(enc(head[10:7])));
            check_eq("noerror",   32'(s == 3'd0), 32'(head[13:11] == 3'd0));
        end
        if (do_push) begin
            q.push_back({inj, d, inject(enc(d), inj)});
            if (inj != 3'd0) m_inj = m_inj + 16'd1;
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET     = 1'b1;
        DIN_VALID = 1'b0;
        DIN       = 4'd0;
        INJ_POS   = 3'd0;
        CW_READY  = 1'b0;
        m_tx      = '0;
        m_inj     = '0;
        @(negedge CLK);

        do_reset(2);

        // Known codewords
        cycle(1'b1, 4'b1011, 3'd0, 1'b1);
        check_eq("enc_1011", 32'(CW), 32'(7'b1010101));
        cycle(1'b1, 4'h0, 3'd0, 1'b1);
        check_eq("enc_0", 32'(CW), 32'(7'b0000000));
        cycle(1'b1, 4'hF, 3'd0, 1'b1);
        check_eq("enc_f", 32'(CW), 32'(7'b1111111));
        cycle(1'b0, 4'h0, 3'd0, 1'b1);

        // Injection into position 3
        do_reset(2);
        cycle(1'b1, 4'b1011, 3'd3, 1'b1);
        check_eq("inj_cw",    32'(CW),        32'(7'b1000101));
        check_eq("inj_count1", 32'(INJ_COUNT), 32'd1);
        cycle(1'b0, 4'h0, 3'd0, 1'b1);

        // Backpressure: fifth word refused, order preserved on release
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'(i + 3), 3'd0, 1'b0);
            if (i == 3) check_eq("full_ready", 32'(DIN_READY), 32'd0);
        end
        check_eq("bp_head", 32'(CW), 32'(enc(4'd3)));
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 3'd0, 1'b1);
        check_eq("bp_tx_count", 32'(TX_COUNT), 32'd4);

        // Full FIFO refuses a push even when popping the same cycle
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i), 3'd0, 1'b0);
        cycle(1'b1, 4'hA, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 3'd0, 1'b1);

        // Streaming: one word per cycle
        do_reset(2);
        for (int i = 0; i < 100; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 3'd0, 1'b1);
        cycle(1'b0, 4'h0, 3'd0, 1'b1);
        check_eq("stream_tx_count", 32'(TX_COUNT), 32'd100);

        // Random traffic with random injection and backpressure
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 3'd0, 1'b1);

        // Reset mid-stream discards buffered words
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 9), 3'd1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 3'd0, 1'b1);
        check_eq("post_rst_valid", 32'(CW_VALID), 32'd0);
        check_eq("post_rst_tx",    32'(TX_COUNT), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
